// File: rtl/even_counter_pkg.sv
// Shared definitions for the even up/down counter sequencer.
//   state_t        : sequencer FSM states
//   CNT_STEP       : magnitude of one counter step
//   CNT_POSITIONS  : number of distinct even counter positions
package even_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  localparam int unsigned CNT_STEP      = 2;
  localparam int unsigned CNT_POSITIONS = 8;

endpackage

// File: rtl/even_counter_seq_dir_sel.sv
// even_dir_sel: combinational direction and step distance from the current
// counter state to a requested target.
// Build option: SHORTEST_PATH_EN selects the wrap-around shortest path;
// otherwise the counter never wraps (up iff target > state).
// Ports:
//   state_i  [WIDTH] current counter state
//   target_i [WIDTH] requested counter value
//   up_o             1 = count up (+2), 0 = count down (-2)
//   dist_o   [WIDTH] number of steps in the chosen direction
module even_dir_sel
  import even_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] state_i,
  input  logic [WIDTH-1:0] target_i,
  output logic             up_o,
  output logic [WIDTH-1:0] dist_o
);

`ifdef SHORTEST_PATH_EN
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] up_dist;
  logic [WIDTH-1:0] down_dist;

  always_comb begin
    diff      = target_i - state_i;          // modular distance going up
    up_dist   = diff >> 1;
    down_dist = WIDTH'(CNT_POSITIONS) - up_dist;
    up_o      = (up_dist <= down_dist);      // a tie goes up
    dist_o    = up_o ? up_dist : down_dist;
  end
`else
  always_comb begin
    up_o   = (target_i > state_i);
    dist_o = up_o ? ((target_i - state_i) >> 1) : ((state_i - target_i) >> 1);
  end
`endif

endmodule

// File: rtl/even_counter_seq.sv
// even_counter_seq: sequences the even up/down counter to a requested target.
// Accepts a target over valid/ready, drives the counter direction and enable
// until the fed-back state equals the target, then pulses done (or err for an
// odd target / exhausted step budget). All outputs are registered.
// Build option: SHORTEST_PATH_EN (see even_dir_sel).
// Ports:
//   clock, reset (sync, active-low)
//   req_valid/req_target/req_ready : request handshake
//   abort                          : cancel a running request
//   cnt_state                      : counter state fed back
//   cnt_y, cnt_en                  : counter direction / enable
//   done, err                      : one-cycle completion / error pulses
module even_counter_seq
  import even_counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_STEPS = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [WIDTH-1:0] req_target,
  output logic             req_ready,
  input  logic             abort,
  input  logic [WIDTH-1:0] cnt_state,
  output logic             cnt_y,
  output logic             cnt_en,
  output logic             done,
  output logic             err
);

  localparam int unsigned      SW         = $clog2(MAX_STEPS + 1);
  localparam logic [WIDTH-1:0] STEP       = WIDTH'(CNT_STEP);
  localparam logic [SW-1:0]    STEP_LIMIT = SW'(MAX_STEPS);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic             dir_q, dir_d;
  logic [SW-1:0]    step_q, step_d;

  logic             req_ready_q, cnt_y_q, cnt_en_q, done_q, err_q;

  logic             sel_up;
  logic [WIDTH-1:0] dist_unused;
  logic [WIDTH-1:0] cnt_next;

  even_dir_sel #(
    .WIDTH (WIDTH)
  ) u_dir_sel (
    .state_i  (cnt_state),
    .target_i (req_target),
    .up_o     (sel_up),
    .dist_o   (dist_unused)
  );

  // Value the counter will show after this edge while enabled; matching it
  // against the target drops cnt_en in the same cycle the target appears.
  assign cnt_next = dir_q ? (cnt_state + STEP) : (cnt_state - STEP);

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    dir_d    = dir_q;
    step_d   = step_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          target_d = req_target;
          dir_d    = sel_up;
          step_d   = '0;
          if (req_target[0])              state_d = ST_ERR;
          else if (req_target == cnt_state) state_d = ST_DONE;
          else                            state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        step_d = step_q + SW'(1);
        if (abort)                     state_d = ST_IDLE;
        else if (cnt_next == target_q) state_d = ST_DONE;
        else if (step_d == STEP_LIMIT) state_d = ST_ERR;
      end
      ST_DONE, ST_ERR: state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      target_q    <= '0;
      dir_q       <= 1'b0;
      step_q      <= '0;
      req_ready_q <= 1'b0;
      cnt_y_q     <= 1'b0;
      cnt_en_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      dir_q       <= dir_d;
      step_q      <= step_d;
      // Moore outputs registered from the next state so they align with it.
      req_ready_q <= (state_d == ST_IDLE);
      cnt_y_q     <= dir_d;
      cnt_en_q    <= (state_d == ST_RUN);
      done_q      <= (state_d == ST_DONE);
      err_q       <= (state_d == ST_ERR);
    end
  end

  assign req_ready = req_ready_q;
  assign cnt_y     = cnt_y_q;
  assign cnt_en    = cnt_en_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_even_counter_seq.sv
// Self-checking bench for even_counter_seq with a behavioural counter model
// and a request-level reference model.
module tb_even_counter_seq;

  localparam int MAXS = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid = 1'b0;
  logic [3:0] req_target = '0;
  logic       req_ready;
  logic       abort = 1'b0;
  logic [3:0] cnt = '0;
  logic       cnt_y, cnt_en, done, err;

  logic       load_en = 1'b0;
  logic [3:0] load_val = '0;
  logic       stuck_mode = 1'b0;

  int tests_run = 0;
  int fails = 0;

  even_counter_seq #(
    .WIDTH     (4),
    .MAX_STEPS (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_target (req_target),
    .req_ready  (req_ready),
    .abort      (abort),
    .cnt_state  (cnt),
    .cnt_y      (cnt_y),
    .cnt_en     (cnt_en),
    .done       (done),
    .err        (err)
  );

  always #5 clock = ~clock;

  // The counter being sequenced: +/-2 per enabled edge, optional stuck mode.
  always @(posedge clock) begin
    if (load_en) cnt <= load_val;
    else if (cnt_en && !stuck_mode) cnt <= cnt_y ? cnt + 4'd2 : cnt - 4'd2;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  // Reference: request outcome from start state s, target t, abort cycle a.
  function automatic void model(input logic [3:0] s, input logic [3:0] t,
                                input int a, input bit stuck,
                                output int en, output bit up, output int done_at,
                                output int err_at, output int ready_at,
                                output logic [3:0] fin);
    int d, k, krun, tmp;
    up = 1'b1; done_at = -1; err_at = -1; fin = s; en = 0;
    if (t[0]) begin
      err_at = 1; ready_at = 2;
    end else if (t == s) begin
      done_at = 1; ready_at = 2;
    end else begin
`ifdef SHORTEST_PATH_EN
      d  = (((int'(t) - int'(s)) % 16 + 16) % 16) / 2;
      up = (d <= 8 - d);
      k  = up ? d : 8 - d;
`else
      up = (t > s);
      k  = up ? (int'(t) - int'(s)) / 2 : (int'(s) - int'(t)) / 2;
`endif
      krun = stuck ? MAXS : k;
      if (a >= 1 && a <= krun) begin
        en = a; ready_at = a + 1;
        tmp = stuck ? int'(s) : (int'(s) + (up ? 2 : -2) * a) & 15;
        fin = tmp[3:0];
      end else if (stuck) begin
        en = MAXS; err_at = MAXS + 1; ready_at = MAXS + 2;
      end else begin
        en = k; done_at = k + 1; ready_at = k + 2; fin = t;
      end
    end
  endfunction

  task automatic load_counter(input logic [3:0] s);
    @(negedge clock);
    load_val = s; load_en = 1'b1;
    @(negedge clock);
    load_en = 1'b0;
  endtask

  // Drives one request and records what the DUT did, cycle 1 = after handshake.
  task automatic do_request(input logic [3:0] s, input logic [3:0] t,
                            input bit stuck, input int abort_at,
                            output int en_n, output logic y_seen, output bit y_mixed,
                            output int done_at, output int done_n,
                            output int err_at, output int err_n,
                            output int ready_at, output logic [3:0] fin);
    load_counter(s);
    stuck_mode = stuck;
    for (int w = 0; w < 20 && !req_ready; w++) @(negedge clock);
    req_valid = 1'b1; req_target = t;
    en_n = 0; y_seen = 1'b0; y_mixed = 1'b0; done_at = -1; done_n = 0;
    err_at = -1; err_n = 0; ready_at = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clock);
      req_valid = 1'b0;
      if (cnt_en) begin
        if (en_n == 0) y_seen = cnt_y;
        else if (cnt_y !== y_seen) y_mixed = 1'b1;
        en_n++;
      end
      if (done) begin done_n++; if (done_at < 0) done_at = c; end
      if (err)  begin err_n++;  if (err_at < 0)  err_at = c;  end
      if (req_ready) begin ready_at = c; break; end
      abort = (c == abort_at);
    end
    abort = 1'b0;
    stuck_mode = 1'b0;
    fin = cnt;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    tests_run++; if (cnt_en !== 1'b0) begin fails++; $display("FAIL rst_cnt_en: got %b expected 0", cnt_en); end
    tests_run++; if (cnt_y !== 1'b0)  begin fails++; $display("FAIL rst_cnt_y: got %b expected 0", cnt_y); end
    tests_run++; if (done !== 1'b0)   begin fails++; $display("FAIL rst_done: got %b expected 0", done); end
    tests_run++; if (err !== 1'b0)    begin fails++; $display("FAIL rst_err: got %b expected 0", err); end
    reset = 1'b1;
    @(negedge clock);
    tests_run++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_basic_up();
    int en_n, da, dn, ea, en2, ra; logic y; bit ym; logic [3:0] f;
    do_request(4'd0, 4'd6, 1'b0, 0, en_n, y, ym, da, dn, ea, en2, ra, f);
    tests_run++; if (en_n != 3) begin fails++; $display("FAIL basic_en_cycles: got %0d expected 3", en_n); end
    tests_run++; if ({ym, y} !== 2'b01) begin fails++; $display("FAIL basic_y: got %b expected 01", {ym, y}); end
    tests_run++; if (da != 4 || dn != 1) begin fails++; $display("FAIL basic_done: got at %0d x%0d expected at 4 x1", da, dn); end
    tests_run++; if (en2 != 0) begin fails++; $display("FAIL basic_err: got %0d expected 0", en2); end
    tests_run++; if (ra != 5) begin fails++; $display("FAIL basic_ready: got %0d expected 5", ra); end
    tests_run++; if (f !== 4'd6) begin fails++; $display("FAIL basic_final: got %0d expected 6", f); end
  endtask

  task automatic test_wrap();
    int en_n, da, dn, ea, en2, ra, ek; logic y, ey; bit ym; logic [3:0] f;
`ifdef SHORTEST_PATH_EN
    ey = 1'b0; ek = 2;
`else
    ey = 1'b1; ek = 6;
`endif
    do_request(4'd2, 4'd14, 1'b0, 0, en_n, y, ym, da, dn, ea, en2, ra, f);
    tests_run++; if ({ym, y} !== {1'b0, ey}) begin fails++; $display("FAIL wrap_y: got %b expected %b", {ym, y}, {1'b0, ey}); end
    tests_run++; if (en_n != ek) begin fails++; $display("FAIL wrap_steps: got %0d expected %0d", en_n, ek); end
    tests_run++; if (da != ek + 1) begin fails++; $display("FAIL wrap_done: got %0d expected %0d", da, ek + 1); end
    tests_run++; if (f !== 4'd14) begin fails++; $display("FAIL wrap_final: got %0d expected 14", f); end
  endtask

  task automatic test_odd_and_zero();
    int en_n, da, dn, ea, en2, ra; logic y; bit ym; logic [3:0] f;
    do_request(4'd0, 4'd5, 1'b0, 0, en_n, y, ym, da, dn, ea, en2, ra, f);
    tests_run++; if (ea != 1 || en2 != 1) begin fails++; $display("FAIL odd_err: got at %0d x%0d expected at 1 x1", ea, en2); end
    tests_run++; if (en_n != 0) begin fails++; $display("FAIL odd_en: got %0d expected 0", en_n); end
    tests_run++; if (dn != 0) begin fails++; $display("FAIL odd_done: got %0d expected 0", dn); end
    do_request(4'd8, 4'd8, 1'b0, 0, en_n, y, ym, da, dn, ea, en2, ra, f);
    tests_run++; if (da != 1 || dn != 1) begin fails++; $display("FAIL zero_done: got at %0d x%0d expected at 1 x1", da, dn); end
    tests_run++; if (en_n != 0) begin fails++; $display("FAIL zero_en: got %0d expected 0", en_n); end
    tests_run++; if (ra != 2) begin fails++; $display("FAIL zero_ready: got %0d expected 2", ra); end
  endtask

  task automatic test_abort();
    int en_n, da, dn, ea, en2, ra; logic y; bit ym; logic [3:0] f, ef;
`ifdef SHORTEST_PATH_EN
    ef = 4'd12;   // shortest path runs down 0 -> 14 -> 12
`else
    ef = 4'd4;
`endif
    do_request(4'd0, 4'd12, 1'b0, 2, en_n, y, ym, da, dn, ea, en2, ra, f);
    tests_run++; if (en_n != 2) begin fails++; $display("FAIL abort_en: got %0d expected 2", en_n); end
    tests_run++; if (f !== ef) begin fails++; $display("FAIL abort_hold: got %0d expected %0d", f, ef); end
    tests_run++; if (dn != 0 || en2 != 0) begin fails++; $display("FAIL abort_pulses: got done %0d err %0d expected 0 0", dn, en2); end
    tests_run++; if (ra != 3) begin fails++; $display("FAIL abort_ready: got %0d expected 3", ra); end
  endtask

  task automatic test_stuck();
    int en_n, da, dn, ea, en2, ra; logic y; bit ym; logic [3:0] f;
    do_request(4'd0, 4'd4, 1'b1, 0, en_n, y, ym, da, dn, ea, en2, ra, f);
    tests_run++; if (en_n != MAXS) begin fails++; $display("FAIL stuck_en: got %0d expected %0d", en_n, MAXS); end
    tests_run++; if (ea != MAXS + 1 || en2 != 1) begin fails++; $display("FAIL stuck_err: got at %0d x%0d expected at %0d x1", ea, en2, MAXS + 1); end
    tests_run++; if (dn != 0) begin fails++; $display("FAIL stuck_done: got %0d expected 0", dn); end
    tests_run++; if (f !== 4'd0) begin fails++; $display("FAIL stuck_final: got %0d expected 0", f); end
  endtask

  task automatic test_reset_mid_run();
    load_counter(4'd0);
    req_valid = 1'b1; req_target = 4'd8;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    tests_run++; if (cnt_en !== 1'b0) begin fails++; $display("FAIL midrst_en: got %b expected 0", cnt_en); end
    tests_run++; if (done !== 1'b0)   begin fails++; $display("FAIL midrst_done: got %b expected 0", done); end
    tests_run++; if (err !== 1'b0)    begin fails++; $display("FAIL midrst_err: got %b expected 0", err); end
    reset = 1'b1;
    @(negedge clock);
    tests_run++; if (req_ready !== 1'b1) begin fails++; $display("FAIL midrst_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_random();
    int en_n, da, dn, ea, en2, ra, a;
    int x_en, x_da, x_ea, x_ra; bit x_up;
    logic y; bit ym; logic [3:0] f, x_f, s, t;
    for (int i = 0; i < 24; i++) begin
      s = 4'(2 * $urandom_range(0, 7));
      t = 4'($urandom_range(0, 15));
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      model(s, t, a, 1'b0, x_en, x_up, x_da, x_ea, x_ra, x_f);
      do_request(s, t, 1'b0, a, en_n, y, ym, da, dn, ea, en2, ra, f);
      tests_run++; if (en_n != x_en) begin fails++; $display("FAIL rnd%0d_en s=%0d t=%0d a=%0d: got %0d expected %0d", i, s, t, a, en_n, x_en); end
      tests_run++; if (da != x_da || dn != (x_da > 0 ? 1 : 0)) begin fails++; $display("FAIL rnd%0d_done s=%0d t=%0d: got at %0d x%0d expected at %0d", i, s, t, da, dn, x_da); end
      tests_run++; if (ea != x_ea || en2 != (x_ea > 0 ? 1 : 0)) begin fails++; $display("FAIL rnd%0d_err s=%0d t=%0d: got at %0d x%0d expected at %0d", i, s, t, ea, en2, x_ea); end
      tests_run++; if (ra != x_ra) begin fails++; $display("FAIL rnd%0d_ready s=%0d t=%0d: got %0d expected %0d", i, s, t, ra, x_ra); end
      tests_run++; if (f !== x_f) begin fails++; $display("FAIL rnd%0d_final s=%0d t=%0d: got %0d expected %0d", i, s, t, f, x_f); end
      if (x_en > 0) begin
        tests_run++; if ({ym, y} !== {1'b0, x_up}) begin fails++; $display("FAIL rnd%0d_y s=%0d t=%0d: got %b expected %b", i, s, t, {ym, y}, {1'b0, x_up}); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_up();
    test_wrap();
    test_odd_and_zero();
    test_abort();
    test_stuck();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
